regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port register file for the next datapath generation.
- Configurable data width, depth and read-port count; two write ports with fixed priority.
- Optional write-to-read bypass and optional hardwired zero register.
- Per-register busy scoreboard: set on issue, cleared on writeback. The hazard unit uses it to stall on pending multi-cycle results.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
- NUM_RD, 2, number of read ports (1..4)
- BYPASS, 1, 1 = a read of a register written this cycle returns the write data
- ZERO_REG, 1, 1 = register 0 always reads 0, ignores writes, never busy

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- RdReg  in  NUM_RD*ADDR_W  packed read addresses; port k = bits [k*ADDR_W +: ADDR_W]
- RdData  out  NUM_RD*DATA_W  packed read data, same packing
- RdBusy  out  NUM_RD  busy bit of the register addressed by each read port
- WrEn0  in  1  write port 0 enable
- WrReg0  in  ADDR_W  write port 0 address
- WrData0  in  DATA_W  write port 0 data
- WrEn1  in  1  write port 1 enable (higher priority)
- WrReg1  in  ADDR_W  write port 1 address
- WrData1  in  DATA_W  write port 1 data
- IssEn  in  1  mark IssReg pending
- IssReg  in  ADDR_W  register whose result is now outstanding
- AnyBusy  out  1  OR of all busy bits

Behaviour:
- Reset (async assert, state cleared immediately):
  - all registers = 0 and all busy bits = 0.
  - RdData = 0, RdBusy = 0 and AnyBusy = 0 while rst is high.
  - Reset mid-operation discards any write or issue in that cycle.
- Writes:
  - Take effect at the rising edge when WrEnX = 1.
  - When ZERO_REG = 1, any write to address 0 is ignored.
  - Both ports enabled to the same address: port 1 data is stored and port 0 is dropped.
  - Different addresses: both are stored in the same cycle.
- Reads are combinational, zero latency:
  - BYPASS = 0: RdData[k] = stored value.
  - BYPASS = 1: if WrEn1 and WrReg1 == RdReg[k], return WrData1. Else if WrEn0 and WrReg0 == RdReg[k], return WrData0. Else return the stored value.
  - Address 0 with ZERO_REG = 1 returns 0 regardless of bypass.
- Scoreboard, next-state per register r:
  - set = IssEn && IssReg == r.
  - clr = (WrEn0 && WrReg0 == r) || (WrEn1 && WrReg1 == r).
  - busy_next = set ? 1 : (clr ? 0 : busy).
  - Set wins over clear in the same cycle, so a new issue is not lost to an older writeback.
  - Register 0 is never set when ZERO_REG = 1.
- RdBusy:
  - RdBusy[k] = busy[RdReg[k]], registered state only.
  - A clear in the current cycle is not bypassed into RdBusy; the bit drops the cycle after writeback.
  - When BYPASS = 1, RdData already carries the forwarded value in that cycle.
- Other rules:
  - A write with no outstanding issue is legal: data is stored, busy stays 0.
  - IssEn with no later write leaves the register busy indefinitely; no timeout.
  - No address range checking; DEPTH = 2**ADDR_W, so all addresses are valid.

Test Plan:
- Reset, then read all addresses -> RdData = 0, RdBusy = 0, AnyBusy = 0; write reg 5 = 0xDEADBEEF, next cycle read port 0 at 5 -> 0xDEADBEEF.
- Same-cycle conflict: WrEn0 reg 7 = 0x11, WrEn1 reg 7 = 0x22 -> bypass read of reg 7 that cycle = 0x22, stored 0x22; repeat with BYPASS = 0 -> that cycle reads old value 0, next cycle 0x22.
- Zero register: write 0x1234 to reg 0 on both ports plus IssEn at reg 0 -> reg 0 reads 0, RdBusy = 0, AnyBusy = 0.
- Scoreboard: IssEn reg 9 -> next cycle RdBusy = 1 on a port reading 9, AnyBusy = 1; WrEn0 reg 9 = 0xA5 -> same cycle RdData = 0xA5, RdBusy still 1; next cycle RdBusy = 0.
- Simultaneous IssEn reg 3 and WrEn1 reg 3 = 0x77 -> reg 3 = 0x77 and busy = 1 afterwards.
- Assert rst asynchronously between edges with regs 1..4 written and reg 2 busy -> RdData and RdBusy go 0 before the next edge; a write presented during reset is not stored.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port register file with two prioritised write ports, optional bypass,
// optional hardwired zero register and a per-register busy scoreboard.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_RD*ADDR_W-1:0]   RdReg,
  output logic [NUM_RD*DATA_W-1:0]   RdData,
  output logic [NUM_RD-1:0]          RdBusy,
  input  logic                       WrEn0,
  input  logic [ADDR_W-1:0]          WrReg0,
  input  logic [DATA_W-1:0]          WrData0,
  input  logic                       WrEn1,
  input  logic [ADDR_W-1:0]          WrReg1,
  input  logic [DATA_W-1:0]          WrData1,
  input  logic                       IssEn,
  input  logic [ADDR_W-1:0]          IssReg,
  output logic                       AnyBusy
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] r_mem;
  logic [DEPTH-1:0]             r_busy;
  logic [DEPTH-1:0]             w_busy_next;
  logic                         w_we0;
  logic                         w_we1;

  assign w_we0 = WrEn0 && !((ZERO_REG != 0) && (WrReg0 == '0));
  assign w_we1 = WrEn1 && !((ZERO_REG != 0) && (WrReg1 == '0));

  // Set wins over clear so a fresh issue is never lost to an older writeback.
  always_comb begin
    w_busy_next = r_busy;
    for (int r = 0; r < DEPTH; r++) begin
      if (IssEn && (IssReg == ADDR_W'(r))) begin
        w_busy_next[r] = 1'b1;
      end else if ((WrEn0 && (WrReg0 == ADDR_W'(r))) ||
                   (WrEn1 && (WrReg1 == ADDR_W'(r)))) begin
        w_busy_next[r] = 1'b0;
      end
    end
    if (ZERO_REG != 0) begin
      w_busy_next[0] = 1'b0;
    end
  end

  // Port 1 is written last so it overrides port 0 on an address collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem  <= '0;
      r_busy <= '0;
    end else begin
      if (w_we0) r_mem[WrReg0] <= WrData0;
      if (w_we1) r_mem[WrReg1] <= WrData1;
      r_busy <= w_busy_next;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;

    assign w_addr = RdReg[k*ADDR_W +: ADDR_W];

    always_comb begin
      w_data = r_mem[w_addr];
      if (BYPASS != 0) begin
        if (WrEn1 && (WrReg1 == w_addr)) begin
          w_data = WrData1;
        end else if (WrEn0 && (WrReg0 == w_addr)) begin
          w_data = WrData0;
        end
      end
      if ((ZERO_REG != 0) && (w_addr == '0)) w_data = '0;
      if (rst) w_data = '0;
    end

    assign RdData[k*DATA_W +: DATA_W] = w_data;
    // Registered busy only: a same-cycle writeback drops the bit one cycle later.
    assign RdBusy[k] = !rst && r_busy[w_addr];
  end

  assign AnyBusy = !rst && (|r_busy);

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp; a bypass and a non-bypass instance share stimulus.
module tb_regfile_mp;

  logic        clk;
  logic        rst;
  logic [9:0]  rd_reg;
  logic        wr_en0, wr_en1, iss_en;
  logic [4:0]  wr_reg0, wr_reg1, iss_reg;
  logic [31:0] wr_data0, wr_data1;

  logic [63:0] rd_data_b, rd_data_nb;
  logic [1:0]  rd_busy_b, rd_busy_nb;
  logic        any_b, any_nb;

  int checks = 0;
  int errors = 0;

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(1), .ZERO_REG(1)) dut_b (
    .clk(clk), .rst(rst), .RdReg(rd_reg), .RdData(rd_data_b), .RdBusy(rd_busy_b),
    .WrEn0(wr_en0), .WrReg0(wr_reg0), .WrData0(wr_data0),
    .WrEn1(wr_en1), .WrReg1(wr_reg1), .WrData1(wr_data1),
    .IssEn(iss_en), .IssReg(iss_reg), .AnyBusy(any_b)
  );

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(0), .ZERO_REG(1)) dut_nb (
    .clk(clk), .rst(rst), .RdReg(rd_reg), .RdData(rd_data_nb), .RdBusy(rd_busy_nb),
    .WrEn0(wr_en0), .WrReg0(wr_reg0), .WrData0(wr_data0),
    .WrEn1(wr_en1), .WrReg1(wr_reg1), .WrData1(wr_data1),
    .IssEn(iss_en), .IssReg(iss_reg), .AnyBusy(any_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en0 = 0; wr_en1 = 0; iss_en = 0;
  endtask

  task automatic test_reset();
    logic [31:0] a;
    #1;
    if ({rd_data_b, rd_data_nb, rd_busy_b, rd_busy_nb, any_b, any_nb} !== '0) begin
      errors++;
      $display("FAIL reset_hold: data_b=%h busy_b=%b any_b=%b", rd_data_b, rd_busy_b, any_b);
    end
    checks++;
    step();
    rst = 0;
    for (int i = 0; i < 32; i++) begin
      rd_reg = {5'(31 - i), 5'(i)};
      #1;
      if ({rd_data_b, rd_data_nb, rd_busy_b, rd_busy_nb, any_b, any_nb} !== '0) begin
        errors++;
        $display("FAIL reset_read addr=%0d: data_b=%h data_nb=%h busy_b=%b", i, rd_data_b, rd_data_nb, rd_busy_b);
      end
      checks++;
    end
    wr_en0 = 1; wr_reg0 = 5; wr_data0 = 32'hDEADBEEF;
    step();
    idle_inputs();
    rd_reg = {5'd0, 5'd5};
    #1;
    a = 32'hDEADBEEF;
    if (rd_data_b[31:0] !== a || rd_data_nb[31:0] !== a) begin
      errors++;
      $display("FAIL write_read5: got_b=%h got_nb=%h want=%h", rd_data_b[31:0], rd_data_nb[31:0], a);
    end
    checks++;
  endtask

  task automatic test_conflict();
    wr_en0 = 1; wr_reg0 = 7; wr_data0 = 32'h11;
    wr_en1 = 1; wr_reg1 = 7; wr_data1 = 32'h22;
    rd_reg = {5'd0, 5'd7};
    #1;
    if (rd_data_b[31:0] !== 32'h22) begin
      errors++; $display("FAIL conflict_bypass: got=%h want=00000022", rd_data_b[31:0]);
    end
    checks++;
    if (rd_data_nb[31:0] !== 32'h0) begin
      errors++; $display("FAIL conflict_nobypass: got=%h want=00000000", rd_data_nb[31:0]);
    end
    checks++;
    step();
    idle_inputs();
    #1;
    if (rd_data_b[31:0] !== 32'h22 || rd_data_nb[31:0] !== 32'h22) begin
      errors++; $display("FAIL conflict_stored: got_b=%h got_nb=%h want=00000022", rd_data_b[31:0], rd_data_nb[31:0]);
    end
    checks++;
    // Distinct addresses on both ports are both stored.
    wr_en0 = 1; wr_reg0 = 10; wr_data0 = 32'hAA;
    wr_en1 = 1; wr_reg1 = 11; wr_data1 = 32'hBB;
    rd_reg = {5'd11, 5'd10};
    #1;
    if (rd_data_b !== {32'hBB, 32'hAA}) begin
      errors++; $display("FAIL dual_bypass: got=%h want=000000bb000000aa", rd_data_b);
    end
    checks++;
    step();
    idle_inputs();
    #1;
    if (rd_data_nb !== {32'hBB, 32'hAA}) begin
      errors++; $display("FAIL dual_stored: got=%h want=000000bb000000aa", rd_data_nb);
    end
    checks++;
  endtask

  task automatic test_zero();
    wr_en0 = 1; wr_reg0 = 0; wr_data0 = 32'h1234;
    wr_en1 = 1; wr_reg1 = 0; wr_data1 = 32'h1234;
    iss_en = 1; iss_reg = 0;
    rd_reg = {5'd0, 5'd0};
    #1;
    if (rd_data_b !== 64'h0 || rd_data_nb !== 64'h0) begin
      errors++; $display("FAIL zero_same_cycle: got_b=%h got_nb=%h want=0", rd_data_b, rd_data_nb);
    end
    checks++;
    step();
    idle_inputs();
    #1;
    if (rd_data_b !== 64'h0 || rd_busy_b !== 2'b00 || any_b !== 1'b0 || any_nb !== 1'b0) begin
      errors++; $display("FAIL zero_after: data=%h busy=%b any=%b want data=0 busy=00 any=0", rd_data_b, rd_busy_b, any_b);
    end
    checks++;
  endtask

  task automatic test_scoreboard();
    iss_en = 1; iss_reg = 9;
    rd_reg = {5'd9, 5'd0};
    #1;
    if (rd_busy_b[1] !== 1'b0 || any_b !== 1'b0) begin
      errors++; $display("FAIL sb_issue_cycle: busy=%b any=%b want 0 0", rd_busy_b[1], any_b);
    end
    checks++;
    step();
    idle_inputs();
    #1;
    if (rd_busy_b[1] !== 1'b1 || any_b !== 1'b1 || rd_busy_nb[1] !== 1'b1) begin
      errors++; $display("FAIL sb_busy: busy=%b any=%b want 1 1", rd_busy_b[1], any_b);
    end
    checks++;
    wr_en0 = 1; wr_reg0 = 9; wr_data0 = 32'hA5;
    #1;
    if (rd_data_b[63:32] !== 32'hA5 || rd_busy_b[1] !== 1'b1) begin
      errors++; $display("FAIL sb_writeback_cycle: data=%h busy=%b want 000000a5 1", rd_data_b[63:32], rd_busy_b[1]);
    end
    checks++;
    if (rd_data_nb[63:32] !== 32'h0) begin
      errors++; $display("FAIL sb_writeback_nobypass: data=%h want 00000000", rd_data_nb[63:32]);
    end
    checks++;
    step();
    idle_inputs();
    #1;
    if (rd_busy_b[1] !== 1'b0 || any_b !== 1'b0 || rd_data_nb[63:32] !== 32'hA5) begin
      errors++; $display("FAIL sb_cleared: busy=%b any=%b data_nb=%h want 0 0 000000a5", rd_busy_b[1], any_b, rd_data_nb[63:32]);
    end
    checks++;
  endtask

  task automatic test_set_wins();
    iss_en = 1; iss_reg = 3;
    wr_en1 = 1; wr_reg1 = 3; wr_data1 = 32'h77;
    rd_reg = {5'd0, 5'd3};
    step();
    idle_inputs();
    #1;
    if (rd_data_b[31:0] !== 32'h77 || rd_busy_b[0] !== 1'b1 || any_b !== 1'b1) begin
      errors++; $display("FAIL set_wins: data=%h busy=%b any=%b want 00000077 1 1", rd_data_b[31:0], rd_busy_b[0], any_b);
    end
    checks++;
    wr_en0 = 1; wr_reg0 = 3; wr_data0 = 32'h78;
    step();
    idle_inputs();
    #1;
    if (rd_data_nb[31:0] !== 32'h78 || rd_busy_nb[0] !== 1'b0 || any_nb !== 1'b0) begin
      errors++; $display("FAIL set_wins_clear: data=%h busy=%b any=%b want 00000078 0 0", rd_data_nb[31:0], rd_busy_nb[0], any_nb);
    end
    checks++;
  endtask

  task automatic test_async_reset();
    wr_en0 = 1; wr_reg0 = 1; wr_data0 = 32'h101;
    wr_en1 = 1; wr_reg1 = 2; wr_data1 = 32'h202;
    step();
    wr_en0 = 1; wr_reg0 = 3; wr_data0 = 32'h303;
    wr_en1 = 1; wr_reg1 = 4; wr_data1 = 32'h404;
    iss_en = 1; iss_reg = 2;
    step();
    idle_inputs();
    rd_reg = {5'd4, 5'd2};
    #1;
    if (rd_data_nb !== {32'h404, 32'h202} || rd_busy_nb !== 2'b01) begin
      errors++; $display("FAIL pre_reset: data=%h busy=%b want 0000040400000202 01", rd_data_nb, rd_busy_nb);
    end
    checks++;
    #1;
    rst = 1;
    wr_en0 = 1; wr_reg0 = 6; wr_data0 = 32'h66;
    iss_en = 1; iss_reg = 6;
    #1;
    if ({rd_data_b, rd_data_nb, rd_busy_b, rd_busy_nb, any_b, any_nb} !== '0) begin
      errors++; $display("FAIL async_reset: data_b=%h busy_b=%b any_b=%b want 0", rd_data_b, rd_busy_b, any_b);
    end
    checks++;
    step();
    idle_inputs();
    rst = 0;
    rd_reg = {5'd1, 5'd6};
    #1;
    if ({rd_data_b, rd_data_nb, rd_busy_b, rd_busy_nb, any_b, any_nb} !== '0) begin
      errors++; $display("FAIL reset_discard: data_b=%h busy_b=%b any_b=%b want 0", rd_data_b, rd_busy_b, any_b);
    end
    checks++;
  endtask

  initial begin
    rst = 1;
    rd_reg = '0;
    wr_reg0 = '0; wr_reg1 = '0; iss_reg = '0;
    wr_data0 = '0; wr_data1 = '0;
    idle_inputs();
    test_reset();
    test_conflict();
    test_zero();
    test_scoreboard();
    test_set_wins();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
